dcache_ctrl_2way: RTL and testbench
===================================

Name: dcache_ctrl_2way

Overview:
- Data-cache controller between the CPU memory stage and the 2-way, 16-set dcache tag/data SRAM.
- Decodes CPU load/store requests and drives index, tag and line data into the SRAM.
- Stalls the CPU on a miss, writes back a dirty victim, refills the line from main memory, then replays the access as a hit.
- Sits directly upstream of the SRAM and downstream of the pipeline MEM stage.

Parameters:
- ADDR_W, 32, byte address width.
- IDX_W, 4, set index bits (16 sets).
- OFF_W, 5, line offset bits (32-byte / 256-bit line).
- TAG_W, ADDR_W-IDX_W-OFF_W = 23, stored tag bits.
- CNT_W, 16, width of saturating hit/miss counters.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- cpu_req_i  in  1  load/store valid
- cpu_we_i  in  1  1 = store
- cpu_addr_i  in  32  byte address, word aligned
- cpu_data_i  in  32  store data
- cpu_data_o  out  32  load data
- cpu_stall_o  out  1  CPU must hold request and freeze pipeline
- sram_enable_o  out  1  SRAM access enable
- sram_write_o  out  1  SRAM write strobe
- sram_addr_o  out  4  set index
- sram_tag_o  out  25  {valid, dirty, tag[22:0]}
- sram_data_o  out  256  line to write
- sram_tag_i  in  25  hit way tag, or LRU victim tag on miss
- sram_data_i  in  256  hit way line, or victim line on miss
- sram_hit_i  in  1  tag match in a valid way
- mem_enable_o  out  1  memory request
- mem_write_o  out  1  1 = write line
- mem_addr_o  out  32  line address, offset bits zero
- mem_data_o  out  256  writeback line
- mem_data_i  in  256  refill line
- mem_ack_i  in  1  one-cycle completion pulse
- hit_cnt_o  out  CNT_W  saturating hit count
- miss_cnt_o  out  CNT_W  saturating miss count

Behaviour:
- Reset is asynchronous and active-high; clock is clk_i. Reset forces state IDLE and clears every register and counter.
- Outputs while in reset: cpu_stall_o=0, mem_enable_o=0, mem_write_o=0, sram_write_o=0, cpu_data_o=0.
- Address split: tag = addr[31:9], index = addr[8:5], word = addr[4:2].
- sram_enable_o = cpu_req_i | (state != IDLE). sram_addr_o always carries the index of the current request.
- States: IDLE, MISS, WRITEBACK, REFILL, REFILL_DONE.
- IDLE, hit (cpu_req_i & sram_hit_i):
  - Load: combinational cpu_data_o = sram_data_i word[word]; zero-cycle latency; no stall.
  - Store: same cycle drives sram_write_o=1, sram_data_o = sram_data_i with word[word] replaced by cpu_data_i, sram_tag_o = {1,1,tag}.
  - hit_cnt increments.
- IDLE, miss (cpu_req_i & ~sram_hit_i): cpu_stall_o=1 combinationally; go to MISS; miss_cnt increments once per miss.
- MISS (1 cycle):
  - Latch victim tag and data from sram_tag_i/sram_data_i into registers.
  - If victim valid & dirty, go to WRITEBACK; else go to REFILL.
- WRITEBACK:
  - Drive mem_enable_o=1, mem_write_o=1, mem_addr_o = {victim tag, index, 5'b0}, mem_data_o = latched victim line.
  - Signals are held level until the mem_ack_i cycle; on ack go to REFILL.
- REFILL:
  - Drive mem_enable_o=1, mem_write_o=0, mem_addr_o = {tag, index, 5'b0}; hold until ack.
  - On ack, register mem_data_i and go to REFILL_DONE.
- REFILL_DONE (1 cycle):
  - Drive sram_write_o=1, sram_tag_o = {1, cpu_we_i, tag}.
  - sram_data_o = refill line, with the store word merged if cpu_we_i.
  - Go to IDLE. The SRAM performs LRU replacement.
- Replay: the next IDLE cycle re-evaluates the held request, which now hits and counts as a hit. cpu_stall_o is 1 in every non-IDLE state.
- Minimum miss penalty: clean miss 3 cycles plus memory latency; dirty miss adds one memory round trip.
- mem_ack_i outside WRITEBACK/REFILL is ignored. An ack in the first cycle of a state is accepted.
- Counters saturate at all-ones and never wrap.
- Reset mid-transaction: immediate return to IDLE and the memory request drops. A partially refilled line is never written to the SRAM.
- cpu_addr_i, cpu_we_i and cpu_data_i must stay stable while cpu_stall_o=1. The bench asserts this.

Decomposition:
- Package dcache_pkg holds:
  - IDX_W, OFF_W, TAG_W, LINE_W=256.
  - State enum.
  - Tag-field bit positions: VALID=24, DIRTY=23, TAG=22:0.
  - Function word_merge(line, word_idx, data).
- One natural sub-module, dcache_word_mux: word extract and word merge on a 256-bit line. It is used for both load data and store merge.

Test Plan:
- Cold load 0x0000_0040:
  - Stall, MISS, REFILL with mem_addr_o=0x40 and mem_write_o=0.
  - Ack with line whose word0=0xDEADBEEF gives REFILL_DONE tag {1,0,0}, then the hit returns 0xDEADBEEF.
  - miss_cnt=1, hit_cnt=1.
- Store hit 0x44 ← 0x12345678: no stall; same cycle sram_write_o=1, word1 replaced, sram_tag_o dirty bit=1.
- Dirty eviction: fill both ways of index 2 dirty, then access a third tag:
  - WRITEBACK with mem_addr_o equal to the LRU victim line address and mem_data_o equal to the victim line.
  - Then REFILL of the new address.
- Store miss on a clean set: REFILL, then REFILL_DONE writes the merged line with the dirty bit set; no WRITEBACK occurs.
- mem_ack_i delayed 0 and 10 cycles: mem_enable_o is held level until ack, and stall covers the full interval.
- rst_i pulsed during WRITEBACK: outputs clear asynchronously, no SRAM write occurs, and counters read 0.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and constants for the 2-way data-cache controller.
// Line geometry, tag-field layout and the word-merge helper.
package dcache_pkg;

  localparam int IDX_W  = 4;
  localparam int OFF_W  = 5;
  localparam int TAG_W  = 32 - IDX_W - OFF_W;
  localparam int LINE_W = 256;
  localparam int WORD_W = 32;
  localparam int WSEL_W = 3;
  localparam int TAGF_W = TAG_W + 2;

  localparam int VALID_B = 24;
  localparam int DIRTY_B = 23;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MISS,
    S_WB,
    S_REFILL,
    S_DONE
  } state_e;

  function automatic logic [LINE_W-1:0] word_merge(
    input logic [LINE_W-1:0] line,
    input logic [WSEL_W-1:0] word_idx,
    input logic [WORD_W-1:0] data
  );
    logic [LINE_W-1:0] r;
    r = line;
    r[{word_idx, 5'b0} +: WORD_W] = data;
    return r;
  endfunction

endpackage

// File: rtl/dcache_word_mux.sv
// Word select and word merge on one cache line.
// Serves load data extraction and store data merging.
module dcache_word_mux
  import dcache_pkg::*;
(
  input  logic [LINE_W-1:0] line_i,
  input  logic [WSEL_W-1:0] word_i,
  input  logic [WORD_W-1:0] data_i,
  output logic [WORD_W-1:0] word_o,
  output logic [LINE_W-1:0] merged_o
);

  assign word_o   = line_i[{word_i, 5'b0} +: WORD_W];
  assign merged_o = word_merge(line_i, word_i, data_i);

endmodule

// File: rtl/dcache_ctrl_2way.sv
// Data-cache controller: hit service, dirty writeback, refill, replay.
// Sits between the MEM stage and the 2-way, 16-set tag/data SRAM.
module dcache_ctrl_2way
  import dcache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_stall_o,
  output logic              sram_enable_o,
  output logic              sram_write_o,
  output logic [3:0]        sram_addr_o,
  output logic [24:0]       sram_tag_o,
  output logic [255:0]      sram_data_o,
  input  logic [24:0]       sram_tag_i,
  input  logic [255:0]      sram_data_i,
  input  logic              sram_hit_i,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [255:0]      mem_data_o,
  input  logic [255:0]      mem_data_i,
  input  logic              mem_ack_i,
  output logic [CNT_W-1:0]  hit_cnt_o,
  output logic [CNT_W-1:0]  miss_cnt_o
);

  state_e state_q, state_d;

  logic [TAG_W-1:0]  tag;
  logic [IDX_W-1:0]  idx;
  logic [WSEL_W-1:0] wsel;

  logic [TAG_W-1:0]  vtag_q;
  logic [LINE_W-1:0] vdata_q;
  logic [LINE_W-1:0] rdata_q;
  logic [CNT_W-1:0]  hit_cnt_q;
  logic [CNT_W-1:0]  miss_cnt_q;

  logic [LINE_W-1:0] mux_line;
  logic [WORD_W-1:0] mux_word;
  logic [LINE_W-1:0] mux_merged;

  logic idle_hit, idle_miss;

  logic              stall;
  logic              s_we;
  logic [TAGF_W-1:0] s_tag;
  logic [LINE_W-1:0] s_data;
  logic              m_en;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [LINE_W-1:0] m_data;
  logic [WORD_W-1:0] c_data;

  logic unused_ok;

  assign tag  = cpu_addr_i[OFF_W+IDX_W +: TAG_W];
  assign idx  = cpu_addr_i[OFF_W +: IDX_W];
  assign wsel = cpu_addr_i[2 +: WSEL_W];
  assign unused_ok = ^cpu_addr_i[1:0];

  assign idle_hit  = (state_q == S_IDLE) & cpu_req_i & sram_hit_i;
  assign idle_miss = (state_q == S_IDLE) & cpu_req_i & ~sram_hit_i;

  // Refill merge works on the registered memory line, hits on the SRAM line.
  assign mux_line = (state_q == S_DONE) ? rdata_q : sram_data_i;

  dcache_word_mux u_mux (
    .line_i   (mux_line),
    .word_i   (wsel),
    .data_i   (cpu_data_i),
    .word_o   (mux_word),
    .merged_o (mux_merged)
  );

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    s_we    = 1'b0;
    s_tag   = {2'b00, tag};
    s_data  = '0;
    m_en    = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_data  = '0;
    c_data  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (idle_hit) begin
          if (cpu_we_i) begin
            s_we   = 1'b1;
            s_tag  = {1'b1, 1'b1, tag};
            s_data = mux_merged;
          end else begin
            c_data = mux_word;
          end
        end else if (idle_miss) begin
          stall   = 1'b1;
          state_d = S_MISS;
        end
      end
      S_MISS: begin
        stall = 1'b1;
        if (sram_tag_i[VALID_B] && sram_tag_i[DIRTY_B]) begin
          state_d = S_WB;
        end else begin
          state_d = S_REFILL;
        end
      end
      S_WB: begin
        stall  = 1'b1;
        m_en   = 1'b1;
        m_we   = 1'b1;
        m_addr = {vtag_q, idx, {OFF_W{1'b0}}};
        m_data = vdata_q;
        if (mem_ack_i) state_d = S_REFILL;
      end
      S_REFILL: begin
        stall  = 1'b1;
        m_en   = 1'b1;
        m_addr = {tag, idx, {OFF_W{1'b0}}};
        if (mem_ack_i) state_d = S_DONE;
      end
      S_DONE: begin
        stall   = 1'b1;
        s_we    = 1'b1;
        s_tag   = {1'b1, cpu_we_i, tag};
        s_data  = cpu_we_i ? mux_merged : rdata_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset masks the handshake outputs at once, independent of the clock.
  assign cpu_stall_o   = stall & ~rst_i;
  assign sram_write_o  = s_we & ~rst_i;
  assign mem_enable_o  = m_en & ~rst_i;
  assign mem_write_o   = m_we & ~rst_i;
  assign cpu_data_o    = rst_i ? '0 : c_data;
  assign sram_tag_o    = s_tag;
  assign sram_data_o   = s_data;
  assign mem_addr_o    = m_addr;
  assign mem_data_o    = m_data;
  assign sram_addr_o   = idx;
  assign sram_enable_o = cpu_req_i | (state_q != S_IDLE);
  assign hit_cnt_o     = hit_cnt_q;
  assign miss_cnt_o    = miss_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      vtag_q  <= '0;
      vdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_MISS) begin
        vtag_q  <= sram_tag_i[TAG_W-1:0];
        vdata_q <= sram_data_i;
      end
      if (state_q == S_REFILL && mem_ack_i) begin
        rdata_q <= mem_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (idle_hit && hit_cnt_q != '1) begin
        hit_cnt_q <= hit_cnt_q + CNT_W'(1);
      end
      if (idle_miss && miss_cnt_q != '1) begin
        miss_cnt_q <= miss_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dcache_ctrl_2way.sv
// Directed bench for dcache_ctrl_2way with a behavioural 2-way LRU SRAM.
// Memory responses are driven by hand with fixed ack delays.
module tb_dcache_ctrl_2way;

  logic         clk;
  logic         rst;
  logic         req;
  logic         we;
  logic [31:0]  addr;
  logic [31:0]  wdata;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         sram_enable_o;
  logic         sram_write_o;
  logic [3:0]   sram_addr_o;
  logic [24:0]  sram_tag_o;
  logic [255:0] sram_data_o;
  logic [24:0]  sram_tag_i;
  logic [255:0] sram_data_i;
  logic         sram_hit_i;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mdata;
  logic         ack;
  logic [15:0]  hit_cnt_o;
  logic [15:0]  miss_cnt_o;

  int nchk;
  int nerr;

  localparam logic [255:0] L1 =
    256'h77777777_66666666_55555555_44444444_33333333_22222222_11111111_DEADBEEF;
  localparam logic [255:0] L1S =
    256'h77777777_66666666_55555555_44444444_33333333_22222222_12345678_DEADBEEF;
  localparam logic [255:0] L2 =
    256'hA7A7A7A7_A6A6A6A6_A5A5A5A5_A4A4A4A4_A3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
  localparam logic [255:0] L2M =
    256'hA7A7A7A7_A6A6A6A6_A5A5A5A5_A4A4A4A4_A3A3A3A3_A2A2A2A2_A1A1A1A1_CAFEF00D;
  localparam logic [255:0] L3 =
    256'hC7C7C7C7_C6C6C6C6_C5C5C5C5_C4C4C4C4_C3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0;

  dcache_ctrl_2way dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cpu_req_i     (req),
    .cpu_we_i      (we),
    .cpu_addr_i    (addr),
    .cpu_data_i    (wdata),
    .cpu_data_o    (cpu_data_o),
    .cpu_stall_o   (cpu_stall_o),
    .sram_enable_o (sram_enable_o),
    .sram_write_o  (sram_write_o),
    .sram_addr_o   (sram_addr_o),
    .sram_tag_o    (sram_tag_o),
    .sram_data_o   (sram_data_o),
    .sram_tag_i    (sram_tag_i),
    .sram_data_i   (sram_data_i),
    .sram_hit_i    (sram_hit_i),
    .mem_enable_o  (mem_enable_o),
    .mem_write_o   (mem_write_o),
    .mem_addr_o    (mem_addr_o),
    .mem_data_o    (mem_data_o),
    .mem_data_i    (mdata),
    .mem_ack_i     (ack),
    .hit_cnt_o     (hit_cnt_o),
    .miss_cnt_o    (miss_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: lookup returns the hit way, else the LRU victim.
  logic [24:0]  tagm [2][16];
  logic [255:0] datm [2][16];
  logic         lru  [16];
  logic         model_clr;
  logic         h0, h1, way;
  int           wr_cnt;

  always_comb begin
    h0 = tagm[0][sram_addr_o][24] && (tagm[0][sram_addr_o][22:0] == addr[31:9]);
    h1 = tagm[1][sram_addr_o][24] && (tagm[1][sram_addr_o][22:0] == addr[31:9]);
    way = (h0 | h1) ? h1 : lru[sram_addr_o];
    sram_hit_i  = h0 | h1;
    sram_tag_i  = tagm[way][sram_addr_o];
    sram_data_i = datm[way][sram_addr_o];
  end

  always @(posedge clk) begin
    if (model_clr) begin
      for (int w = 0; w < 2; w++) begin
        for (int s = 0; s < 16; s++) begin
          tagm[w][s] <= '0;
          datm[w][s] <= '0;
        end
      end
      for (int s = 0; s < 16; s++) lru[s] <= 1'b0;
      wr_cnt <= 0;
    end else if (sram_enable_o && sram_write_o) begin
      tagm[way][sram_addr_o] <= sram_tag_o;
      datm[way][sram_addr_o] <= sram_data_o;
      lru[sram_addr_o] <= ~way;
      wr_cnt <= wr_cnt + 1;
    end else if (sram_enable_o && sram_hit_i) begin
      lru[sram_addr_o] <= ~way;
    end
  end

  task automatic chk(input string tg, input logic [255:0] obs,
                     input logic [255:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tg, obs, exp);
    end
  endtask

  logic         hold;
  logic [65:0]  held;

  // Each cycle: the request must not move while the previous cycle stalled.
  task automatic tick();
    if (hold) chk("cpu_hold", {req, we, addr, wdata}, held);
    hold = cpu_stall_o;
    held = {req, we, addr, wdata};
    @(posedge clk);
    #1;
  endtask

  int wc;

  initial begin
    nchk = 0; nerr = 0; hold = 1'b0; held = '0;
    rst = 1'b1; model_clr = 1'b1;
    req = 1'b1; we = 1'b0; addr = 32'h40; wdata = '0;
    ack = 1'b0; mdata = '0;
    tick(); tick();
    chk("rst_stall", cpu_stall_o, 0);
    chk("rst_mem_en", mem_enable_o, 0);
    chk("rst_mem_we", mem_write_o, 0);
    chk("rst_sram_we", sram_write_o, 0);
    chk("rst_cpu_data", cpu_data_o, 0);
    chk("rst_hit", hit_cnt_o, 0);
    chk("rst_miss", miss_cnt_o, 0);
    req = 1'b0; rst = 1'b0; model_clr = 1'b0;
    tick();

    // cold load 0x40
    req = 1'b1; we = 1'b0; addr = 32'h40;
    #1;
    chk("cold_stall", cpu_stall_o, 1);
    chk("cold_idx", sram_addr_o, 2);
    chk("cold_sram_en", sram_enable_o, 1);
    tick();
    chk("cold_miss_cnt", miss_cnt_o, 1);
    chk("cold_miss_mem_en", mem_enable_o, 0);
    tick();
    chk("cold_rf_en", mem_enable_o, 1);
    chk("cold_rf_we", mem_write_o, 0);
    chk("cold_rf_addr", mem_addr_o, 32'h40);
    ack = 1'b1; mdata = L1;
    tick();
    ack = 1'b0;
    #1;
    chk("cold_done_we", sram_write_o, 1);
    chk("cold_done_tag", sram_tag_o, 25'h1000000);
    chk("cold_done_data", sram_data_o, L1);
    chk("cold_done_stall", cpu_stall_o, 1);
    chk("cold_done_mem_en", mem_enable_o, 0);
    tick();
    chk("cold_replay_stall", cpu_stall_o, 0);
    chk("cold_replay_data", cpu_data_o, 32'hDEADBEEF);
    tick();
    req = 1'b0;
    #1;
    chk("cold_hit_cnt", hit_cnt_o, 1);
    chk("cold_miss_cnt2", miss_cnt_o, 1);

    // store hit 0x44
    req = 1'b1; we = 1'b1; addr = 32'h44; wdata = 32'h12345678;
    #1;
    chk("st_stall", cpu_stall_o, 0);
    chk("st_we", sram_write_o, 1);
    chk("st_tag", sram_tag_o, 25'h1800000);
    chk("st_data", sram_data_o, L1S);
    tick();
    we = 1'b0;
    #1;
    chk("ld_back", cpu_data_o, 32'h12345678);
    tick();
    req = 1'b0;
    #1;
    chk("st_hit_cnt", hit_cnt_o, 3);

    // store miss into clean way, ack delayed 10 cycles
    req = 1'b1; we = 1'b1; addr = 32'h240; wdata = 32'hCAFEF00D;
    #1;
    chk("sm_stall", cpu_stall_o, 1);
    tick();
    chk("sm_miss_mem_en", mem_enable_o, 0);
    tick();
    chk("sm_rf_en", mem_enable_o, 1);
    chk("sm_rf_we", mem_write_o, 0);
    chk("sm_rf_addr", mem_addr_o, 32'h240);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("sm_wait_en", mem_enable_o, 1);
      chk("sm_wait_stall", cpu_stall_o, 1);
    end
    ack = 1'b1; mdata = L2;
    tick();
    ack = 1'b0;
    #1;
    chk("sm_done_we", sram_write_o, 1);
    chk("sm_done_tag", sram_tag_o, 25'h1800001);
    chk("sm_done_data", sram_data_o, L2M);
    chk("sm_miss_cnt", miss_cnt_o, 2);
    tick();
    chk("sm_replay_stall", cpu_stall_o, 0);
    chk("sm_replay_we", sram_write_o, 1);
    tick();
    req = 1'b0; we = 1'b0;
    #1;
    chk("sm_hit_cnt", hit_cnt_o, 4);

    // dirty eviction at index 2, ack with zero delay
    req = 1'b1; addr = 32'h440;
    #1;
    chk("ev_stall", cpu_stall_o, 1);
    tick();
    tick();
    chk("ev_wb_en", mem_enable_o, 1);
    chk("ev_wb_we", mem_write_o, 1);
    chk("ev_wb_addr", mem_addr_o, 32'h40);
    chk("ev_wb_data", mem_data_o, L1S);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    #1;
    chk("ev_rf_en", mem_enable_o, 1);
    chk("ev_rf_we", mem_write_o, 0);
    chk("ev_rf_addr", mem_addr_o, 32'h440);
    ack = 1'b1; mdata = L3;
    tick();
    ack = 1'b0;
    #1;
    chk("ev_done_tag", sram_tag_o, 25'h1000002);
    chk("ev_done_data", sram_data_o, L3);
    tick();
    chk("ev_replay_stall", cpu_stall_o, 0);
    chk("ev_replay_data", cpu_data_o, 32'hC0C0C0C0);
    tick();
    req = 1'b0;
    #1;
    chk("ev_miss_cnt", miss_cnt_o, 3);
    chk("ev_hit_cnt", hit_cnt_o, 5);

    // reset pulsed during writeback of the dirty tag-1 line
    req = 1'b1; addr = 32'h640;
    tick();
    tick();
    chk("rw_wb_en", mem_enable_o, 1);
    chk("rw_wb_we", mem_write_o, 1);
    chk("rw_wb_addr", mem_addr_o, 32'h240);
    chk("rw_wb_data", mem_data_o, L2M);
    wc = wr_cnt;
    #2;
    rst = 1'b1;
    #1;
    chk("rw_mem_en", mem_enable_o, 0);
    chk("rw_mem_we", mem_write_o, 0);
    chk("rw_stall", cpu_stall_o, 0);
    chk("rw_sram_we", sram_write_o, 0);
    chk("rw_cpu_data", cpu_data_o, 0);
    chk("rw_hit", hit_cnt_o, 0);
    chk("rw_miss", miss_cnt_o, 0);
    tick();
    tick();
    chk("rw_no_sram_wr", wr_cnt, wc);
    rst = 1'b0; req = 1'b0;
    tick();
    chk("rw_post_hit", hit_cnt_o, 0);
    chk("rw_post_miss", miss_cnt_o, 0);
    chk("rw_post_stall", cpu_stall_o, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
